fft_iter_stream: RTL and testbench

- Parametrised radix-2 decimation-in-time FFT/IFFT with Avalon-ST framed input and output.
- Successor to the fixed 64-point streaming FFT: point count and data widths are generics.
- Adds a per-frame inverse select and a frame error flag.
- Sits between the audio sample framer and the pitch/peak detector; one frame is in flight at a time (load, compute, unload).

---
 rtl/fft_iter_pkg.sv | 39 +++
 rtl/fft_iter_stream_bfly.sv | 59 +++++
 rtl/fft_iter_stream.sv | 239 +++++++++++++++++++++++
 tb/tb_fft_iter_stream.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_iter_pkg.sv
// fft_iter_pkg: shared types and elaboration-time helpers for fft_iter_stream.
// Holds the FSM encoding, bit reversal, twiddle generation and error bit indices.
package fft_iter_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        UNLOAD
    } state_t;

    localparam int ERR_LEN = 0;
    localparam int ERR_UP  = 1;

    function automatic int bitrev(input int k, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            r = r | (((k >> i) & 1) << (bits - 1 - i));
        end
        return r;
    endfunction

    // cos (sel=0) or sin (sel=1) of 2*pi*m/2**log2n in Q1.(tw_w-1); +1.0 clamps
    function automatic int twiddle(input int m, input int log2n,
                                   input int tw_w, input bit sel);
        real ang;
        real v;
        int  q;
        int  lim;
        ang = 2.0 * 3.14159265358979323846 * real'(m) / real'(1 << log2n);
        v   = sel ? $sin(ang) : $cos(ang);
        v   = v * real'(1 << (tw_w - 1));
        q   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        lim = (1 << (tw_w - 1)) - 1;
        if (q > lim) q = lim;
        return q;
    endfunction

endpackage

// File: rtl/fft_iter_stream_bfly.sv
// fft_bfly: radix-2 DIT butterfly, t = B*W rounded half-up, A' = A+t, B' = A-t.
// With FFT_STAGE_SCALE_EN defined both outputs are halved with round-half-up.
module fft_bfly #(
    parameter int OUT_W = 19,
    parameter int TW_W  = 16
) (
    input  logic signed [OUT_W-1:0] a_re,
    input  logic signed [OUT_W-1:0] a_im,
    input  logic signed [OUT_W-1:0] b_re,
    input  logic signed [OUT_W-1:0] b_im,
    input  logic signed [TW_W-1:0]  w_re,
    input  logic signed [TW_W-1:0]  w_im,
    output logic signed [OUT_W-1:0] x_re,
    output logic signed [OUT_W-1:0] x_im,
    output logic signed [OUT_W-1:0] y_re,
    output logic signed [OUT_W-1:0] y_im
);
    localparam int PW = OUT_W + TW_W + 1;
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW_W - 2);

    logic signed [PW-1:0]    p_re;
    logic signed [PW-1:0]    p_im;
    logic signed [OUT_W-1:0] t_re;
    logic signed [OUT_W-1:0] t_im;

    always_comb begin
        p_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im) + RND;
        p_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re) + RND;
        t_re = p_re[TW_W-1 +: OUT_W];
        t_im = p_im[TW_W-1 +: OUT_W];
    end

`ifdef FFT_STAGE_SCALE_EN
    localparam int SW = OUT_W + 1;
    logic signed [SW-1:0] sx_re;
    logic signed [SW-1:0] sx_im;
    logic signed [SW-1:0] sy_re;
    logic signed [SW-1:0] sy_im;

    always_comb begin
        sx_re = SW'(a_re) + SW'(t_re) + SW'(1);
        sx_im = SW'(a_im) + SW'(t_im) + SW'(1);
        sy_re = SW'(a_re) - SW'(t_re) + SW'(1);
        sy_im = SW'(a_im) - SW'(t_im) + SW'(1);
        x_re  = sx_re[SW-1:1];
        x_im  = sx_im[SW-1:1];
        y_re  = sy_re[SW-1:1];
        y_im  = sy_im[SW-1:1];
    end
`else
    always_comb begin
        x_re = a_re + t_re;
        x_im = a_im + t_im;
        y_re = a_re - t_re;
        y_im = a_im - t_im;
    end
`endif

endmodule

// File: rtl/fft_iter_stream.sv
// fft_iter_stream: iterative radix-2 DIT FFT/IFFT with framed streaming I/O.
// Define FFT_STAGE_SCALE_EN to halve every stage so the output is X/N.
module fft_iter_stream
    import fft_iter_pkg::*;
#(
    parameter int LOG2N = 6,
    parameter int IN_W  = 12,
    parameter int TW_W  = 16,
    parameter int OUT_W = IN_W + LOG2N + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sink_valid,
    output logic                    sink_ready,
    input  logic                    sink_sop,
    input  logic                    sink_eop,
    input  logic [1:0]              sink_error,
    input  logic signed [IN_W-1:0]  sink_real,
    input  logic signed [IN_W-1:0]  sink_imag,
    input  logic                    inverse,
    output logic                    source_valid,
    input  logic                    source_ready,
    output logic                    source_sop,
    output logic                    source_eop,
    output logic [1:0]              source_error,
    output logic signed [OUT_W-1:0] source_real,
    output logic signed [OUT_W-1:0] source_imag
);
    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam logic [3:0] LAST_STAGE = 4'(LOG2N - 1);

    state_t state_q, state_d;
    logic sink_ready_q, sink_ready_d;
    logic in_frame_q, in_frame_d;
    logic inv_q, inv_d;
    logic [1:0] err_q, err_d;
    logic [LOG2N-1:0] k_q, k_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [3:0] stage_q, stage_d;
    logic [LOG2N-2:0] j_q, j_d;
    logic src_valid_q, src_valid_d;
    logic src_sop_q, src_sop_d;
    logic src_eop_q, src_eop_d;
    logic [1:0] src_err_q, src_err_d;
    logic signed [OUT_W-1:0] src_re_q, src_re_d;
    logic signed [OUT_W-1:0] src_im_q, src_im_d;
    logic signed [OUT_W-1:0] mem_re_q [N];
    logic signed [OUT_W-1:0] mem_im_q [N];
    logic signed [OUT_W-1:0] mem_re_d [N];
    logic signed [OUT_W-1:0] mem_im_d [N];

    logic signed [TW_W-1:0] rom_c [HALF];
    logic signed [TW_W-1:0] rom_s [HALF];

    for (genvar g = 0; g < HALF; g++) begin : g_rom
        localparam int C = twiddle(g, LOG2N, TW_W, 1'b0);
        localparam int S = twiddle(g, LOG2N, TW_W, 1'b1);
        assign rom_c[g] = TW_W'(C);
        assign rom_s[g] = TW_W'(S);
    end

    logic beat;
    logic [LOG2N-1:0] pos, wr_addr, rd_addr;
    logic [LOG2N-1:0] j_ext, mask, addr_a, addr_b, tw_full;
    logic [LOG2N-2:0] tw_idx;
    logic signed [TW_W-1:0] w_re, w_im;
    logic signed [OUT_W-1:0] bf_x_re, bf_x_im, bf_y_re, bf_y_im;

    assign beat    = sink_valid && sink_ready_q;
    assign pos     = sink_sop ? '0 : k_q;
    assign wr_addr = LOG2N'(bitrev(int'(pos), LOG2N));
    assign rd_addr = src_valid_q ? cnt_q + 1'b1 : cnt_q;

    // stage s pairs addresses 2**s apart; twiddle step is N/2**(s+1)
    assign j_ext   = {1'b0, j_q};
    assign mask    = (LOG2N'(1) << stage_q) - 1'b1;
    assign addr_a  = ((j_ext >> stage_q) << (stage_q + 4'd1)) | (j_ext & mask);
    assign addr_b  = addr_a | (LOG2N'(1) << stage_q);
    assign tw_full = (j_ext & mask) << (LAST_STAGE - stage_q);
    assign tw_idx  = tw_full[LOG2N-2:0];
    assign w_re    = rom_c[tw_idx];
    assign w_im    = inv_q ? rom_s[tw_idx] : -rom_s[tw_idx];

    fft_bfly #(
        .OUT_W(OUT_W),
        .TW_W (TW_W)
    ) u_bfly (
        .a_re(mem_re_q[addr_a]),
        .a_im(mem_im_q[addr_a]),
        .b_re(mem_re_q[addr_b]),
        .b_im(mem_im_q[addr_b]),
        .w_re(w_re),
        .w_im(w_im),
        .x_re(bf_x_re),
        .x_im(bf_x_im),
        .y_re(bf_y_re),
        .y_im(bf_y_im)
    );

    always_comb begin
        state_d      = state_q;
        sink_ready_d = sink_ready_q;
        in_frame_d   = in_frame_q;
        inv_d        = inv_q;
        err_d        = err_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        stage_d      = stage_q;
        j_d          = j_q;
        src_valid_d  = src_valid_q;
        src_sop_d    = src_sop_q;
        src_eop_d    = src_eop_q;
        src_err_d    = src_err_q;
        src_re_d     = src_re_q;
        src_im_d     = src_im_q;
        mem_re_d     = mem_re_q;
        mem_im_d     = mem_im_q;
        unique case (state_q)
            LOAD: begin
                sink_ready_d = 1'b1;
                if (beat && (sink_sop || in_frame_q)) begin
                    // clearing at sop doubles as the zero-fill for short frames
                    if (sink_sop) begin
                        for (int i = 0; i < N; i++) begin
                            mem_re_d[i] = '0;
                            mem_im_d[i] = '0;
                        end
                        inv_d = inverse;
                        err_d = '0;
                    end
                    mem_re_d[wr_addr] = OUT_W'(sink_real);
                    mem_im_d[wr_addr] = OUT_W'(sink_imag);
                    if (sink_error != 2'b00) err_d[ERR_UP] = 1'b1;
                    in_frame_d = 1'b1;
                    k_d        = pos + 1'b1;
                    if (sink_eop || pos == '1) begin
                        err_d[ERR_LEN] = !(sink_eop && pos == '1);
                        in_frame_d     = 1'b0;
                        k_d            = '0;
                        stage_d        = '0;
                        j_d            = '0;
                        sink_ready_d   = 1'b0;
                        state_d        = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                mem_re_d[addr_a] = bf_x_re;
                mem_im_d[addr_a] = bf_x_im;
                mem_re_d[addr_b] = bf_y_re;
                mem_im_d[addr_b] = bf_y_im;
                j_d = j_q + 1'b1;
                if (j_q == '1) begin
                    stage_d = stage_q + 4'd1;
                    if (stage_q == LAST_STAGE) begin
                        stage_d = '0;
                        state_d = UNLOAD;
                    end
                end
            end
            UNLOAD: begin
                if (!src_valid_q || source_ready) begin
                    if (src_valid_q && src_eop_q) begin
                        src_valid_d  = 1'b0;
                        src_sop_d    = 1'b0;
                        src_eop_d    = 1'b0;
                        src_err_d    = '0;
                        src_re_d     = '0;
                        src_im_d     = '0;
                        err_d        = '0;
                        cnt_d        = '0;
                        sink_ready_d = 1'b1;
                        state_d      = LOAD;
                    end else begin
                        src_valid_d = 1'b1;
                        src_sop_d   = (rd_addr == '0);
                        src_eop_d   = (rd_addr == '1);
                        src_err_d   = err_q;
                        src_re_d    = mem_re_q[rd_addr];
                        src_im_d    = mem_im_q[rd_addr];
                        cnt_d       = rd_addr;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LOAD;
            sink_ready_q <= 1'b0;
            in_frame_q   <= 1'b0;
            inv_q        <= 1'b0;
            err_q        <= '0;
            k_q          <= '0;
            cnt_q        <= '0;
            stage_q      <= '0;
            j_q          <= '0;
            src_valid_q  <= 1'b0;
            src_sop_q    <= 1'b0;
            src_eop_q    <= 1'b0;
            src_err_q    <= '0;
            src_re_q     <= '0;
            src_im_q     <= '0;
        end else begin
            state_q      <= state_d;
            sink_ready_q <= sink_ready_d;
            in_frame_q   <= in_frame_d;
            inv_q        <= inv_d;
            err_q        <= err_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
            stage_q      <= stage_d;
            j_q          <= j_d;
            src_valid_q  <= src_valid_d;
            src_sop_q    <= src_sop_d;
            src_eop_q    <= src_eop_d;
            src_err_q    <= src_err_d;
            src_re_q     <= src_re_d;
            src_im_q     <= src_im_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_re_q <= mem_re_d;
        mem_im_q <= mem_im_d;
    end

    assign sink_ready   = sink_ready_q;
    assign source_valid = src_valid_q;
    assign source_sop   = src_sop_q;
    assign source_eop   = src_eop_q;
    assign source_error = src_err_q;
    assign source_real  = src_re_q;
    assign source_imag  = src_im_q;

endmodule

// File: tb/tb_fft_iter_stream.sv
// tb_fft_iter_stream: directed frames against hand-derived and DFT reference bins.
// Covers impulse, DC, tone, backpressure, short/error frames, round trip, reset.
module tb_fft_iter_stream;
    localparam int LOG2N = 6;
    localparam int N     = 64;
    localparam int IN_W  = 12;
    localparam int TW_W  = 16;
    localparam int OUT_W = 19;
    localparam int LAT   = LOG2N * N / 2 + 1;
    localparam real PI   = 3.14159265358979323846;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sink_valid = 1'b0;
    logic sink_ready;
    logic sink_sop = 1'b0;
    logic sink_eop = 1'b0;
    logic [1:0] sink_error = 2'b00;
    logic signed [IN_W-1:0] sink_real = '0;
    logic signed [IN_W-1:0] sink_imag = '0;
    logic inverse = 1'b0;
    logic source_valid;
    logic source_ready = 1'b1;
    logic source_sop;
    logic source_eop;
    logic [1:0] source_error;
    logic signed [OUT_W-1:0] source_real;
    logic signed [OUT_W-1:0] source_imag;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int eop_cyc = 0;
    int lat = 0;
    int bad_hold = 0;
    int bad_mark = 0;
    int nbins = 0;
    int in_re [N];
    int in_im [N];
    int orig_re [N];
    int orig_im [N];
    int got_re [N];
    int got_im [N];
    int got_err [N];
    real ref_re [N];
    real ref_im [N];

    fft_iter_stream #(
        .LOG2N(LOG2N),
        .IN_W (IN_W),
        .TW_W (TW_W),
        .OUT_W(OUT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sink_valid  (sink_valid),
        .sink_ready  (sink_ready),
        .sink_sop    (sink_sop),
        .sink_eop    (sink_eop),
        .sink_error  (sink_error),
        .sink_real   (sink_real),
        .sink_imag   (sink_imag),
        .inverse     (inverse),
        .source_valid(source_valid),
        .source_ready(source_ready),
        .source_sop  (source_sop),
        .source_eop  (source_eop),
        .source_error(source_error),
        .source_real (source_real),
        .source_imag (source_imag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got,
                       input longint exp, input longint tol);
        longint d;
        n_tests++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic void clear_in();
        for (int k = 0; k < N; k++) begin
            in_re[k] = 0;
            in_im[k] = 0;
        end
    endfunction

    function automatic void ref_dft(input bit inv);
        real a;
        real s;
        s = inv ? 1.0 : -1.0;
        for (int m = 0; m < N; m++) begin
            ref_re[m] = 0.0;
            ref_im[m] = 0.0;
            for (int k = 0; k < N; k++) begin
                a = 2.0 * PI * real'((k * m) % N) / real'(N);
                ref_re[m] += real'(in_re[k]) * $cos(a) - s * real'(in_im[k]) * $sin(a);
                ref_im[m] += real'(in_im[k]) * $cos(a) + s * real'(in_re[k]) * $sin(a);
            end
        end
    endfunction

    function automatic int max_dev();
        int d;
        int mx;
        mx = 0;
        for (int m = 0; m < N; m++) begin
            d = got_re[m] - rnd(ref_re[m]);
            if (d < 0) d = -d;
            if (d > mx) mx = d;
            d = got_im[m] - rnd(ref_im[m]);
            if (d < 0) d = -d;
            if (d > mx) mx = d;
        end
        return mx;
    endfunction

    function automatic int count_bins(input int re, input int im);
        int c;
        c = 0;
        for (int m = 0; m < N; m++) begin
            if (got_re[m] != re || got_im[m] != im) c++;
        end
        return c;
    endfunction

    function automatic int count_err(input int e);
        int c;
        c = 0;
        for (int m = 0; m < N; m++) begin
            if (got_err[m] != e) c++;
        end
        return c;
    endfunction

    task automatic drive_beat(input bit sop, input bit eop, input int re,
                              input int im, input logic [1:0] er, input bit inv);
        int w;
        @(negedge clk);
        sink_valid = 1'b1;
        sink_sop   = sop;
        sink_eop   = eop;
        sink_real  = IN_W'(re);
        sink_imag  = IN_W'(im);
        sink_error = er;
        inverse    = inv;
        w = 0;
        while (!sink_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) chk("sink_ready_wait", 0, 1, 0);
        @(posedge clk);
    endtask

    task automatic send_frame(input int len, input bit inv,
                              input int err_k, input int junk);
        for (int j = 0; j < junk; j++) begin
            drive_beat(1'b0, 1'b0, 999, -999, 2'b00, !inv);
        end
        for (int k = 0; k < len; k++) begin
            drive_beat(k == 0, k == len - 1, in_re[k], in_im[k],
                       (k == err_k) ? 2'b10 : 2'b00, (k == 0) ? inv : !inv);
        end
        @(negedge clk);
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        sink_error = 2'b00;
        eop_cyc    = cyc;
    endtask

    task automatic get_frame(input bit stall);
        int  ph;
        int  guard;
        int  first;
        int  prev_re;
        int  prev_im;
        bit  prev_st;
        bit  rdy;
        nbins    = 0;
        ph       = 0;
        guard    = 0;
        first    = -1;
        prev_st  = 1'b0;
        prev_re  = 0;
        prev_im  = 0;
        bad_hold = 0;
        bad_mark = 0;
        while (nbins < N && guard < 3000) begin
            if (prev_st && (!source_valid || source_real != prev_re ||
                            source_imag != prev_im)) bad_hold++;
            rdy = stall ? (ph % 3 == 2) : 1'b1;
            ph++;
            source_ready = rdy;
            if (source_valid) begin
                if (first < 0) first = cyc;
                if (rdy) begin
                    got_re[nbins]  = int'(source_real);
                    got_im[nbins]  = int'(source_imag);
                    got_err[nbins] = int'(source_error);
                    if (source_sop != (nbins == 0) || source_eop != (nbins == N - 1))
                        bad_mark++;
                    nbins++;
                    prev_st = 1'b0;
                end else begin
                    prev_st = 1'b1;
                    prev_re = int'(source_real);
                    prev_im = int'(source_imag);
                end
            end
            @(negedge clk);
            guard++;
        end
        lat = first - eop_cyc;
        chk("frame_bins", nbins, N, 0);
        chk("valid_after_eop", source_valid, 0, 0);
        chk("error_after_eop", source_error, 0, 0);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        chk("rst_sink_ready", sink_ready, 0, 0);
        chk("rst_source_valid", source_valid, 0, 0);
        chk("rst_source_real", source_real, 0, 0);
        chk("rst_source_error", source_error, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", sink_ready, 1, 0);

        // impulse with leading non-sop beats that must be dropped
        clear_in();
        in_re[0] = 100;
        send_frame(N, 1'b0, -1, 2);
        get_frame(1'b0);
        chk("impulse_bins", count_bins(100, 0), 0, 0);
        chk("impulse_bin63_re", got_re[63], 100, 0);
        chk("impulse_err", count_err(0), 0, 0);
        chk("impulse_sop_eop", bad_mark, 0, 0);
        chk("latency", lat, LAT, 0);

        clear_in();
        for (int k = 0; k < N; k++) in_re[k] = 10;
        send_frame(N, 1'b0, -1, 0);
        get_frame(1'b0);
        chk("dc_bin0_re", got_re[0], 640, 1);
        chk("dc_bin0_im", got_im[0], 0, 1);
        got_re[0] = 0;
        got_im[0] = 0;
        for (int m = 0; m < N; m++) begin
            ref_re[m] = 0.0;
            ref_im[m] = 0.0;
        end
        chk("dc_other_bins", max_dev(), 0, 1);

        clear_in();
        for (int k = 0; k < N; k++) in_re[k] = rnd(1000.0 * $cos(2.0 * PI * 4.0 * k / N));
        send_frame(N, 1'b0, -1, 0);
        get_frame(1'b0);
        ref_dft(1'b0);
        chk("tone_bin4_re", got_re[4], 32000, 8);
        chk("tone_bin60_re", got_re[60], 32000, 8);
        chk("tone_vs_dft", max_dev(), 0, 8);

        // distinct bins so reordering, loss or duplication shows up
        clear_in();
        in_re[1] = 1000;
        send_frame(N, 1'b0, -1, 0);
        get_frame(1'b1);
        ref_dft(1'b0);
        chk("bp_vs_dft", max_dev(), 0, 4);
        chk("bp_hold", bad_hold, 0, 0);
        chk("bp_sop_eop", bad_mark, 0, 0);
        chk("bp_latency", lat, LAT, 0);

        clear_in();
        in_re[0] = 100;
        send_frame(41, 1'b0, -1, 0);
        get_frame(1'b0);
        chk("short_bins", count_bins(100, 0), 0, 0);
        chk("short_err", count_err(1), 0, 0);
        chk("short_latency", lat, LAT, 0);

        send_frame(N, 1'b0, 5, 0);
        get_frame(1'b0);
        chk("uperr_err", count_err(2), 0, 0);
        chk("uperr_bins", count_bins(100, 0), 0, 0);

        clear_in();
        for (int k = 0; k < N; k++) begin
            in_re[k]   = ((k * 7) % 21) - 10;
            in_im[k]   = ((k * 5) % 13) - 6;
            orig_re[k] = in_re[k];
            orig_im[k] = in_im[k];
        end
        send_frame(N, 1'b0, -1, 0);
        get_frame(1'b0);
        ref_dft(1'b0);
        chk("rt_fwd_vs_dft", max_dev(), 0, 4);
        for (int k = 0; k < N; k++) begin
            in_re[k] = got_re[k];
            in_im[k] = got_im[k];
        end
        send_frame(N, 1'b1, -1, 0);
        get_frame(1'b0);
        for (int k = 0; k < N; k++) begin
            ref_re[k] = real'(orig_re[k] * N);
            ref_im[k] = real'(orig_im[k] * N);
        end
        chk("rt_inverse", max_dev(), 0, N);
        chk("rt_bin5_re", got_re[5], orig_re[5] * N, N);

        // abort a frame partway through COMPUTE
        clear_in();
        in_re[0] = 100;
        send_frame(N, 1'b0, -1, 0);
        repeat (50) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_source_valid", source_valid, 0, 0);
        chk("midrst_sink_ready", sink_ready, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", sink_ready, 1, 0);
        seen = 0;
        repeat (LAT + 20) begin
            @(negedge clk);
            if (source_valid) seen++;
        end
        chk("midrst_no_output", seen, 0, 0);
        for (int k = 0; k < N; k++) in_re[k] = 10;
        send_frame(N, 1'b0, -1, 0);
        get_frame(1'b0);
        chk("midrst_dc_bin0", got_re[0], 640, 1);
        chk("midrst_dc_bin1", got_re[1], 0, 1);
        chk("midrst_latency", lat, LAT, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
